// File: rtl/pixel_pkg.sv
// pixel_pkg: shared state encoding, default phase durations and sizing helper
package pixel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    localparam int DEF_ERASE   = 5;
    localparam int DEF_EXPOSE  = 75;
    localparam int DEF_CONVERT = 255;

    // Integer square root, used to derive the array side from its pixel count
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: row/column walker for readout, columns first
module pixel_addr_gen #(
    parameter int SIDE = 2,
    parameter int AW   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic          is_last
);

    localparam logic [AW-1:0] LAST = AW'(SIDE - 1);

    assign is_last = (row == LAST) && (col == LAST);

    // Clear wins over advance; column wraps into the next row
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            col <= (col == LAST) ? '0 : col + 1'b1;
            if (col == LAST) row <= (row == LAST) ? '0 : row + 1'b1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: erase/expose/convert/read frame controller with pixel stream output
module frame_sequencer
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS = 4,
    parameter int CNT_W      = 16,
    parameter int ADC_W      = 8,
    parameter int SIDE       = isqrt(NUM_PIXELS),
    parameter int AW         = (SIDE > 1) ? $clog2(SIDE) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_erase,
    input  logic [CNT_W-1:0] cfg_expose,
    input  logic [CNT_W-1:0] cfg_convert,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic             read,
    output logic [AW-1:0]    row_addr,
    output logic [AW-1:0]    col_addr,
    input  logic [ADC_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [ADC_W-1:0] pix_out,
    output logic             pix_last,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count
);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_erase_len, r_expose_len, r_convert_len, r_cnt, w_len;
    logic               w_phase_end, w_exit, w_latch, w_capture, w_is_last;
    logic               r_valid, r_last, r_done;
    logic [ADC_W-1:0]   r_out;
    logic [15:0]        r_count;

    assign w_len       = (r_state == S_ERASE)  ? r_erase_len  :
                         (r_state == S_EXPOSE) ? r_expose_len : r_convert_len;
    assign w_phase_end = (w_len == '0) || (r_cnt == w_len - 1'b1);
    assign w_exit      = (r_state == S_READ) && r_valid && r_last && pix_ready;
    assign w_capture   = (r_state == S_READ) && !(r_valid && r_last) && (!r_valid || pix_ready);
    assign w_latch     = !abort && (((r_state == S_IDLE) && start) || (w_exit && continuous));

    assign pix_valid   = r_valid;
    assign pix_last    = r_last;
    assign pix_out     = r_out;
    assign frame_done  = r_done;
    assign frame_count = r_count;

    pixel_addr_gen #(.SIDE(SIDE), .AW(AW)) u_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (abort || (r_state != S_READ)),
        .advance (w_capture),
        .row     (row_addr),
        .col     (col_addr),
        .is_last (w_is_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: abort overrides everything, phases advance on counter expiry
    always_comb begin
        w_next = r_state;
        if (abort) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:    w_next = start       ? S_ERASE   : S_IDLE;
                S_ERASE:   w_next = w_phase_end ? S_EXPOSE  : S_ERASE;
                S_EXPOSE:  w_next = w_phase_end ? S_CONVERT : S_EXPOSE;
                S_CONVERT: w_next = w_phase_end ? S_READ    : S_CONVERT;
                S_READ:    w_next = w_exit ? (continuous ? S_ERASE : S_IDLE) : S_READ;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Phase strobes decode directly from the state register
    always_comb begin
        erase   = (r_state == S_ERASE);
        expose  = (r_state == S_EXPOSE);
        convert = (r_state == S_CONVERT);
        read    = (r_state == S_READ);
        busy    = (r_state != S_IDLE);
    end

    // Phase counter restarts at every state change; shadows latch at frame start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_erase_len   <= '0;
            r_expose_len  <= '0;
            r_convert_len <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (w_latch) begin
                r_erase_len   <= cfg_erase;
                r_expose_len  <= cfg_expose;
                r_convert_len <= cfg_convert;
            end
        end
    end

    // Output register: capture when empty or draining, no capture after the last pixel
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_out   <= '0;
        end else if (abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_last  <= w_is_last;
            r_out   <= pix_data;
        end else if (pix_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    // Frame completion pulse and wrapping frame counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= w_exit && !abort;
            if (w_exit && !abort) r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized frame-level checks against a behavioural model
module tb_frame_sequencer;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0, pix_ready = 1'b1;
    logic [15:0] cfg_erase, cfg_expose, cfg_convert;
    logic        erase, expose, convert, read, pix_valid, pix_last, busy, frame_done;
    logic [0:0]  row_addr, col_addr;
    logic [7:0]  pix_data, pix_out;
    logic [15:0] frame_count;
    logic [7:0]  pix_mem [4];
    int          n_tests = 0, n_fail = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    // The array model: code for the addressed pixel, combinational
    assign pix_data = pix_mem[{row_addr, col_addr}];

    frame_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .cfg_erase   (cfg_erase),
        .cfg_expose  (cfg_expose),
        .cfg_convert (cfg_convert),
        .erase       (erase),
        .expose      (expose),
        .convert     (convert),
        .read        (read),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_out     (pix_out),
        .pix_last    (pix_last),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    function automatic int eff(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Distinct codes per pixel so order and duplicates are visible
    task automatic fill_mem();
        for (int i = 0; i < 4; i++) pix_mem[i] = 8'(i * 61 + $urandom_range(0, 50));
    endtask

    task automatic set_cfg(input int e, input int x, input int c);
        cfg_erase   = 16'(e);
        cfg_expose  = 16'(x);
        cfg_convert = 16'(c);
    endtask

    task automatic chk_reset(input string p);
        check({p, "_erase"}, erase, 0);
        check({p, "_expose"}, expose, 0);
        check({p, "_convert"}, convert, 0);
        check({p, "_read"}, read, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_valid"}, pix_valid, 0);
        check({p, "_last"}, pix_last, 0);
        check({p, "_out"}, pix_out, 0);
        check({p, "_row"}, row_addr, 0);
        check({p, "_col"}, col_addr, 0);
        check({p, "_done"}, frame_done, 0);
        check({p, "_count"}, frame_count, 0);
    endtask

    // Start nf back-to-back frames; expectations come from latched cfg and pixel order
    task automatic run_frames(input int nf, input bit bp, input bit chg);
        int cyc, f, ne, nx, nc, nr, es, rr, acc, done_cyc, ee, ex, ec;
        bit pe, px, pr, stall;
        logic [7:0] pv;
        f = 0; ne = 0; nx = 0; nc = 0; nr = 0; es = 0; rr = -10; acc = 0; done_cyc = 0;
        ee = 0; ex = 0; ec = 0; pe = 0; px = 0; pr = 0; stall = 0; pv = 0;
        fill_mem();
        continuous = (nf > 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (f < nf && cyc < 3000 * nf) begin
            pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                check("hold_valid", pix_valid, 1);
                check("hold_data", pix_out, pv);
            end
            if (frame_done) begin
                exp_cnt++;
                f++;
                check("pix_count", acc, 4);
                check("erase_len", ne, ee);
                check("expose_len", nx, ex);
                check("convert_len", nc, ec);
                if (!bp) check("read_len", nr, 5);
                check("frame_count", frame_count, exp_cnt & 16'hFFFF);
                check("busy_after_done", busy, int'(f < nf));
                if (f == nf - 1) continuous = 1'b0;
                done_cyc = cyc;
                ne = 0; nx = 0; nc = 0; nr = 0; acc = 0;
            end
            if (erase && !pe) begin
                es = cyc;
                check("erase_start", es, (f == 0) ? 1 : done_cyc);
                ee = eff(cfg_erase);
                ex = eff(cfg_expose);
                ec = eff(cfg_convert);
            end
            if (expose && !px && chg) set_cfg($urandom_range(0, 6), 10, $urandom_range(0, 6));
            if (read && !pr) begin
                rr = cyc;
                check("read_start", cyc - es, ee + ex + ec);
            end
            if (cyc == rr + 1) check("first_valid", pix_valid, 1);
            ne += int'(erase);
            nx += int'(expose);
            nc += int'(convert);
            nr += int'(read);
            if (pix_valid && pix_ready) begin
                check("pix_data", pix_out, (acc < 4) ? int'(pix_mem[acc]) : -1);
                check("pix_last", pix_last, int'(acc == 3));
                acc++;
            end
            stall = pix_valid && !pix_ready;
            pv = pix_out;
            pe = erase; px = expose; pr = read;
            @(negedge clk);
            cyc++;
        end
        check("frame_timeout", f, nf);
        pix_ready = 1'b1;
    endtask

    initial begin
        int acc;
        set_cfg(5, 75, 255);
        fill_mem();
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;
        @(negedge clk);

        run_frames(1, 0, 0);
        set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
        run_frames(1, 1, 0);
        set_cfg(3, 0, 2);
        run_frames(1, 0, 1);
        set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
        run_frames(4, 1, 1);
        for (int i = 0; i < 6; i++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            run_frames($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort after two accepted pixels
        set_cfg(1, 2, 1);
        fill_mem();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int i = 0; i < 200 && acc < 2; i++) begin
            if (pix_valid && pix_ready) acc++;
            @(negedge clk);
        end
        check("abort_reach", acc, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_read", read, 0);
        check("abort_valid", pix_valid, 0);
        check("abort_last", pix_last, 0);
        check("abort_row", row_addr, 0);
        check("abort_col", col_addr, 0);
        check("abort_done", frame_done, 0);
        check("abort_count", frame_count, exp_cnt);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", frame_done, 0);
        end
        run_frames(1, 0, 0);

        // Reset pulse in the middle of expose
        set_cfg(2, 30, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !expose; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("rst_mid_expose", expose, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        reset_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        run_frames(1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Programmable frame controller for the pixel array. It sequences erase → expose → convert → read with run-time durations latched per frame, single-shot or continuous. It walks the row/column addresses during readout and streams converted pixel codes to the downstream consumer over a valid/ready handshake with backpressure. It sits between the system control logic and the pixel array/ADC datapath.

## Interface
- NUM_PIXELS, 4, array size; must be a perfect square; SIDE = sqrt(NUM_PIXELS), AW = max(1, clog2(SIDE))
- CNT_W, 16, width of duration configuration fields
- ADC_W, 8, pixel code width
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- continuous  in  1  when 1 at end of READ, the next frame starts immediately
- abort  in  1  return to IDLE next cycle from any state
- cfg_erase, cfg_expose, cfg_convert  in  CNT_W each  phase durations in cycles; 0 is treated as 1
- erase, expose, convert, read  out  1  one-hot array phase strobes
- row_addr, col_addr  out  AW  pixel address during READ
- pix_data  in  ADC_W  array code for the current row_addr/col_addr, valid in the same cycle
- pix_valid  out  1  output register holds a pixel
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready
- pix_out  out  ADC_W  registered pixel code
- pix_last  out  1  qualifies the final pixel of the frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  16  completed frames, wraps at 0xFFFF→0

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE: when start=1, latch the cfg_* values into shadow registers and enter ERASE. cfg_* changes mid-frame have no effect.
- ERASE, EXPOSE and CONVERT each last exactly max(1, shadow value) cycles, then advance. The phase counter resets to 0 on every transition.
- The phase strobe is high exactly while in that state. In IDLE all strobes are 0.
- READ uses the address generator, which starts at (0,0) and walks columns first. col wraps at SIDE-1 and increments row; the final address is (SIDE-1, SIDE-1).
- Output register: when it is empty or being accepted, capture pix_data at the current address, set pix_valid, and advance the address. Otherwise hold the address and pix_out.
- pix_last=1 with the capture of (SIDE-1, SIDE-1). No further captures follow it.
- Exit from READ occurs on acceptance of the last pixel:
  - frame_done pulses and frame_count increments.
  - If continuous=1, re-latch cfg_* and go to ERASE; otherwise go to IDLE.
- abort, in any state, takes effect next cycle: state=IDLE, strobes=0, pix_valid=0, addresses=0. No frame_done is issued and frame_count is unchanged. abort takes priority over start and over the READ exit.
- Reset has the same effect as abort, and additionally clears frame_count.

## Timing
- Reset values: all strobes 0, busy 0, pix_valid 0, pix_last 0, pix_out 0, row_addr/col_addr 0, frame_done 0, frame_count 0, state IDLE.
- All outputs are registered.
- start sampled high in cycle t gives erase=1 from cycle t+1.
- Read phase begins at t+1+E+X+C, where E, X and C are the effective erase, expose and convert durations.
- The first pix_valid appears the cycle after read rises.
- With pix_ready held at 1, one pixel is delivered per cycle and READ lasts NUM_PIXELS+1 cycles.
- pix_valid never drops without acceptance, except on abort or reset.
- frame_done is high in the cycle following last acceptance, coincident with the new state.
- Continuous mode leaves no IDLE gap: erase=1 in the cycle after last acceptance.

## Structure
- The shared package pixel_pkg holds:
  - the state enum
  - the default durations (5, 75, 255) for benches
- One sub-module, pixel_addr_gen, provides:
  - clear and advance inputs
  - row and col outputs
  - an is_last flag
- Phase counting and the output register stay in frame_sequencer.

## Test plan
- Single frame, NUM_PIXELS=4, cfg=5/75/255, pix_ready=1, start pulse:
  - erase, expose and convert are high for 5, 75 and 255 cycles respectively.
  - Pixels arrive at addresses (0,0),(0,1),(1,0),(1,1); pix_last is set on the 4th.
  - frame_done pulses once, frame_count=1, busy returns to 0.
- Backpressure, pix_ready toggling 1,0,0,1,…:
  - pix_out and the address hold while stalled.
  - All 4 codes are delivered in order with no duplicates.
- cfg_expose=0: expose is high for exactly 1 cycle. Changing cfg_expose to 10 during the frame does not alter that frame.
- Continuous=1 for 3 frames: no IDLE between frames and frame_count reaches 3. Then drop continuous: IDLE follows after frame 4.
- abort during READ after 2 pixels accepted:
  - IDLE next cycle with pix_valid=0.
  - No frame_done; frame_count unchanged.
  - The next start begins at address (0,0).
- reset_n low for 1 cycle mid-EXPOSE: all outputs take their reset values on the next edge and frame_count=0.
